// File: rtl/queue_pkg.sv
// queue_pkg: shared sizes and types for the byte queue
package queue_pkg;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;
    typedef logic [WIDTH-1:0] byte_t;
endpackage

// File: rtl/byte_queue_if.sv
// byte_queue_if: push/pop request bus and status outputs of the byte queue
interface byte_queue_if;
    import queue_pkg::*;
    byte_t              data_in;
    logic               enqueue_in;
    logic               dequeue_in;
    byte_t              data_out;
    logic [CNT_W-1:0]   len_out;
    logic               empty_out;
    logic               full_out;
    logic               err_out;
    modport master (output data_in, enqueue_in, dequeue_in,
                    input data_out, len_out, empty_out, full_out, err_out);
    modport slave (input data_in, enqueue_in, dequeue_in,
                   output data_out, len_out, empty_out, full_out, err_out);
endinterface

// File: rtl/queue_mem.sv
// queue_mem: register file, one synchronous write port, one asynchronous read port
module queue_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    // storage is never reset; only slots already written are ever read
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/byte_queue.sv
// byte_queue: 8-entry circular-buffer byte FIFO with reject pulse
import queue_pkg::*;
module byte_queue #(
    parameter int DEPTH = queue_pkg::DEPTH,
    parameter int WIDTH = queue_pkg::WIDTH
) (
    input  logic        clock_1MHz,
    input  logic        rst,
    byte_queue_if.slave bus
);
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    byte_t            rdata;
    logic             do_enq, do_deq, reject;

    queue_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk   (clock_1MHz),
        .we    (do_enq),
        .waddr (wptr),
        .wdata (bus.data_in),
        .raddr (rptr),
        .rdata (rdata)
    );

    // a pop frees a slot, so a push into a full queue is accepted when paired with a pop
    always_comb begin
        do_deq = bus.dequeue_in && count != '0;
        do_enq = bus.enqueue_in && (count != CNT_W'(DEPTH) || do_deq);
        reject = (bus.enqueue_in && !do_enq) || (bus.dequeue_in && !do_deq);
    end

    // pointers, occupancy, popped byte and error pulse
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            bus.data_out <= '0;
            bus.err_out  <= 1'b0;
        end else begin
            if (do_enq) wptr <= wptr + 1'b1;
            if (do_deq) begin
                rptr         <= rptr + 1'b1;
                bus.data_out <= rdata;
            end
            count       <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
            bus.err_out <= reject;
        end
    end

    assign bus.len_out   = count;
    assign bus.empty_out = count == '0;
    assign bus.full_out  = count == CNT_W'(DEPTH);
endmodule
